df_mac_o: RTL

- Output-neuron multiply-accumulate sequencer, directly downstream of the output-neuron data mux.
- Drives the mux select to walk the N_IN hidden-layer inputs, then the constant-1.0 bias slot (sel=4'hF).
- Multiplies each selected Q4.12 value by the matching weight and accumulates the products at full precision.
- Returns one saturated Q4.12 neuron result with a one-cycle done pulse.

---
 rtl/df_mac_o.sv | 118 +++++++++++
 1 files changed

// File: rtl/df_mac_o.sv
// rtl/df_mac_o.sv - output-neuron MAC sequencer: walks mux sel over N_IN inputs plus bias, saturated Q4.12 result
// Optional build macro DF_MAC_O_RELU_EN clamps negative results to zero (ReLU).
module df_mac_o #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 4,
    parameter int N_IN       = 15,
    parameter int ACC_WIDTH  = 36
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] weight,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int                   FRAC     = DATA_WIDTH - 4;
    localparam int                   PW       = 2 * DATA_WIDTH;
    localparam logic [SEL_WIDTH-1:0] SEL_BIAS = '1;
    localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(N_IN - 1);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                       state, state_n;
    logic [SEL_WIDTH-1:0]         sel_n;
    logic signed [ACC_WIDTH-1:0]  acc, acc_n;
    logic                         busy_n, done_n;
    logic [DATA_WIDTH-1:0]        result_n;

    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_sh;
    logic [ACC_WIDTH-DATA_WIDTH:0] acc_hi;
    logic [DATA_WIDTH-1:0]        sat_val;

    // Q4.12 x Q4.12 -> Q8.24 at full precision, sign-extended into the accumulator
    assign prod     = $signed(data_i) * $signed(weight);
    assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    assign acc_sh   = acc >>> FRAC;
    assign acc_hi   = acc_sh[ACC_WIDTH-1:DATA_WIDTH-1];

    // In range only when every bit above the Q4.12 sign bit matches it
    always_comb begin
        sat_val = acc_sh[DATA_WIDTH-1:0];
        if (!((&acc_hi) || (~|acc_hi))) begin
            sat_val = acc_sh[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`ifdef DF_MAC_O_RELU_EN
        if (sat_val[DATA_WIDTH-1]) begin
            sat_val = '0;
        end
`endif
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        acc_n    = acc;
        busy_n   = busy;
        done_n   = 1'b0;
        result_n = result;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_n   = '0;
                    sel_n   = '0;
                    busy_n  = 1'b1;
                    state_n = ACC;
                end
            end
            ACC: begin
                acc_n = acc + prod_ext;
                if (sel == SEL_BIAS) begin
                    state_n = OUT;
                end else if (sel == SEL_LAST) begin
                    sel_n = SEL_BIAS;
                end else begin
                    sel_n = sel + SEL_WIDTH'(1);
                end
            end
            OUT: begin
                result_n = sat_val;
                done_n   = 1'b1;
                busy_n   = 1'b0;
                sel_n    = '0;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
                sel_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            sel    <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            acc    <= acc_n;
            busy   <= busy_n;
            done   <= done_n;
            result <= result_n;
        end
    end

endmodule
